// File: rtl/simd_pkg.sv
// Shared types and helpers for the SIMD lane sequencer and the bit-serial lane array.
package simd_pkg;

   localparam int unsigned WIDTH_DEF   = 32;
   localparam int unsigned LANES_DEF   = 4;
   localparam int unsigned TIMEOUT_DEF = 16;
   localparam int unsigned OP_W        = 2;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_STEP = 3'd2,
      ST_WAIT = 3'd3,
      ST_RESP = 3'd4
   } seq_state_t;

   // LSB position of a lane slice inside a packed multi-lane bus
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/simd_done_tracker.sv
// Sticky per-lane done mask and WAIT watchdog for one micro-step of the sequencer.
module simd_done_tracker
   import simd_pkg::*;
#(
   parameter int unsigned LANES       = LANES_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             active,
   input  logic [LANES-1:0] lane_mask,
   input  logic [LANES-1:0] done_bit,
   output logic [LANES-1:0] done_mask_c,
   output logic             all_done_c,
   output logic             timed_out_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [LANES-1:0] done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cnt_last_c;

   // Include this cycle's done pulses so a lane answering in its first WAIT cycle costs no extra cycle
   always_comb begin
      done_mask_c = done_q | (active ? (done_bit & lane_mask) : '0);
      all_done_c  = active && (&(done_mask_c | ~lane_mask));
      cnt_last_c  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
      timed_out_c = active && !all_done_c && cnt_last_c;
   end

   always_comb begin
      done_d = done_q;
      cnt_d  = cnt_q;
      if (clear) begin
         done_d = '0;
         cnt_d  = '0;
      end else if (active) begin
         done_d = done_mask_c;
         if (!cnt_last_c) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= '0;
         cnt_q  <= '0;
      end else begin
         done_q <= done_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/simd_lane_sequencer.sv
// Initiator-side controller: loads a vector command into the bit-serial lanes,
// steps them through WIDTH micro-steps and returns the packed lane results.
module simd_lane_sequencer
   import simd_pkg::*;
#(
   parameter int unsigned WIDTH       = WIDTH_DEF,
   parameter int unsigned LANES       = LANES_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [OP_W-1:0]            cmd_op,
   input  logic [LANES-1:0]           cmd_lane_mask,
   input  logic [LANES*WIDTH-1:0]     cmd_a,
   input  logic [LANES*WIDTH-1:0]     cmd_b,
   output logic                       lane_start_op,
   output logic                       lane_start_bit,
   output logic [$clog2(WIDTH)-1:0]   lane_bit_idx,
   output logic [OP_W-1:0]            lane_op,
   output logic [LANES*WIDTH-1:0]     lane_a,
   output logic [LANES*WIDTH-1:0]     lane_b,
   input  logic [LANES-1:0]           lane_done_bit,
   input  logic [LANES*WIDTH-1:0]     lane_result,
   input  logic [LANES-1:0]           lane_div_by_zero,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [LANES*WIDTH-1:0]     rsp_result,
   output logic [LANES-1:0]           rsp_dbz,
   output logic                       rsp_timeout,
   output logic [LANES-1:0]           rsp_lanes_done
);

   localparam int unsigned IDX_W  = $clog2(WIDTH);
   localparam int unsigned DATA_W = LANES * WIDTH;

   seq_state_t        state_q, state_d;
   op_t               op_q, op_d;
   logic [LANES-1:0]  mask_q, mask_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [LANES-1:0]  dbz_q, dbz_d, ldone_q, ldone_d;
   logic              tmo_q, tmo_d;
   logic              rdy_q, rdy_d;
   logic              sop_q, sop_d;
   logic              sbit_q, sbit_d;
   logic              rvld_q, rvld_d;

   logic              trk_clear_c, trk_active_c, all_done_c, timed_out_c;
   logic [LANES-1:0]  done_mask_c;
   logic [DATA_W-1:0] cap_res_c;
   logic [LANES-1:0]  cap_dbz_c;

   assign trk_clear_c  = (state_q == ST_STEP);
   assign trk_active_c = (state_q == ST_WAIT);

   simd_done_tracker #(
      .LANES       (LANES),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_done_tracker (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (trk_clear_c),
      .active      (trk_active_c),
      .lane_mask   (mask_q),
      .done_bit    (lane_done_bit),
      .done_mask_c (done_mask_c),
      .all_done_c  (all_done_c),
      .timed_out_c (timed_out_c)
   );

   // Masked-off lanes read zero; dbz is only meaningful for DIV
   always_comb begin
      cap_res_c = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (mask_q[i]) begin
            cap_res_c[lane_lsb(i, WIDTH) +: WIDTH] = lane_result[lane_lsb(i, WIDTH) +: WIDTH];
         end
      end
      cap_dbz_c = (op_q == OP_DIV) ? (lane_div_by_zero & mask_q) : '0;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      mask_d  = mask_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      res_d   = res_q;
      dbz_d   = dbz_q;
      tmo_d   = tmo_q;
      ldone_d = ldone_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_d    = op_t'(cmd_op);
               mask_d  = cmd_lane_mask;
               a_d     = cmd_a;
               b_d     = cmd_b;
               idx_d   = '0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_STEP;
         ST_STEP: state_d = ST_WAIT;
         ST_WAIT: begin
            if (all_done_c && (idx_q != IDX_W'(WIDTH - 1))) begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = ST_STEP;
            end else if (all_done_c || timed_out_c) begin
               res_d   = cap_res_c;
               dbz_d   = cap_dbz_c;
               tmo_d   = timed_out_c;
               ldone_d = done_mask_c;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Strobes are registered off the next state so they line up with the state they belong to
      rdy_d  = (state_d == ST_IDLE);
      sop_d  = (state_d == ST_LOAD);
      sbit_d = (state_d == ST_STEP);
      rvld_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_ADD;
         mask_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         res_q   <= '0;
         dbz_q   <= '0;
         tmo_q   <= 1'b0;
         ldone_q <= '0;
         rdy_q   <= 1'b1;
         sop_q   <= 1'b0;
         sbit_q  <= 1'b0;
         rvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mask_q  <= mask_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
         dbz_q   <= dbz_d;
         tmo_q   <= tmo_d;
         ldone_q <= ldone_d;
         rdy_q   <= rdy_d;
         sop_q   <= sop_d;
         sbit_q  <= sbit_d;
         rvld_q  <= rvld_d;
      end
   end

   // The ready flop wakes up set so IDLE can accept right after release; gate it while in reset
   assign cmd_ready      = rdy_q & rst_n;
   assign lane_start_op  = sop_q;
   assign lane_start_bit = sbit_q;
   assign lane_bit_idx   = idx_q;
   assign lane_op        = op_q;
   assign lane_a         = a_q;
   assign lane_b         = b_q;
   assign rsp_valid      = rvld_q;
   assign rsp_result     = res_q;
   assign rsp_dbz        = dbz_q;
   assign rsp_timeout    = tmo_q;
   assign rsp_lanes_done = ldone_q;

endmodule
